// File: rtl/univ_shift_reg_pkg.sv
// Shared mode encodings for the universal shift register and its bit cells.
package univ_shift_reg_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_HOLD = 3'b000;
  localparam mode_t MODE_LOAD = 3'b001;
  localparam mode_t MODE_SHL  = 3'b010;
  localparam mode_t MODE_SHR  = 3'b011;
  localparam mode_t MODE_ROL  = 3'b100;
  localparam mode_t MODE_ROR  = 3'b101;
  localparam mode_t MODE_SAR  = 3'b110;
  localparam mode_t MODE_CLR  = 3'b111;

endpackage

// File: rtl/usr_bit_cell.sv
// One storage bit of the universal register: 8:1 next-state mux feeding a DFF
// with synchronous reset to a per-bit reset value.
module usr_bit_cell
  import univ_shift_reg_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  rst_val_i,
  input  logic  en_i,
  input  mode_t mode_i,
  input  logic  d_i,
  input  logic  shl_i,
  input  logic  shr_i,
  input  logic  rol_i,
  input  logic  ror_i,
  input  logic  sar_i,
  output logic  q_o
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    case (mode_i)
      MODE_HOLD: q_d = q_q;
      MODE_LOAD: q_d = d_i;
      MODE_SHL:  q_d = shl_i;
      MODE_SHR:  q_d = shr_i;
      MODE_ROL:  q_d = rol_i;
      MODE_ROR:  q_d = ror_i;
      MODE_SAR:  q_d = sar_i;
      MODE_CLR:  q_d = 1'b0;
      default:   q_d = q_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= rst_val_i;
    end else if (en_i) begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal register: hold, load, shifts, rotates and clear, with
// complementary outputs, registered carry-out and a zero flag.
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int unsigned       WIDTH       = 32,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [2:0]       MODE,
  input  logic [WIDTH-1:0] D,
  input  logic             SIL,
  input  logic             SIR,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic             CO,
  output logic             ZERO
);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] shl_vec;
  logic [WIDTH-1:0] shr_vec;
  logic [WIDTH-1:0] rol_vec;
  logic [WIDTH-1:0] ror_vec;
  logic [WIDTH-1:0] sar_vec;
  logic             co_q;
  logic             co_d;

  // Neighbour wiring for every one-bit move, resolved here so cells stay uniform.
  assign shl_vec = {q[WIDTH-2:0], SIL};
  assign shr_vec = {SIR, q[WIDTH-1:1]};
  assign rol_vec = {q[WIDTH-2:0], q[WIDTH-1]};
  assign ror_vec = {q[0], q[WIDTH-1:1]};
  assign sar_vec = {q[WIDTH-1], q[WIDTH-1:1]};

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    usr_bit_cell u_cell (
      .clk_i     (CLK),
      .rst_i     (RST),
      .rst_val_i (RESET_VALUE[i]),
      .en_i      (EN),
      .mode_i    (MODE),
      .d_i       (D[i]),
      .shl_i     (shl_vec[i]),
      .shr_i     (shr_vec[i]),
      .rol_i     (rol_vec[i]),
      .ror_i     (ror_vec[i]),
      .sar_i     (sar_vec[i]),
      .q_o       (q[i])
    );
  end

  always_comb begin
    co_d = co_q;
    case (MODE)
      MODE_SHL, MODE_ROL:           co_d = q[WIDTH-1];
      MODE_SHR, MODE_ROR, MODE_SAR: co_d = q[0];
      MODE_CLR:                     co_d = 1'b0;
      default:                      co_d = co_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      co_q <= 1'b0;
    end else if (EN) begin
      co_q <= co_d;
    end
  end

  assign Q    = q;
  assign Qn   = ~q;
  assign CO   = co_q;
  assign ZERO = (q == '0);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: three widths driven in lockstep, checked each cycle
// against an arithmetic reference model, plus directed scenario checks.
module tb_univ_shift_reg;

  localparam logic [7:0]  RV8  = 8'hA5;
  localparam logic [31:0] RV32 = 32'hDEAD_BEEF;
  localparam logic [1:0]  RV2  = 2'b01;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        EN = 1'b0;
  logic [2:0]  MODE = 3'b000;
  logic [31:0] D = '0;
  logic        SIL = 1'b0;
  logic        SIR = 1'b0;

  logic [7:0]  q8, qn8;
  logic [31:0] q32, qn32;
  logic [1:0]  q2, qn2;
  logic        co8, co32, co2, zero8, zero32, zero2;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  logic [31:0] m8 = '0, m32 = '0, m2 = '0;
  logic        c8 = 1'b0, c32 = 1'b0, c2 = 1'b0;

  always #5 CLK = ~CLK;

  univ_shift_reg #(.WIDTH(8), .RESET_VALUE(RV8)) u_dut8 (
    .CLK(CLK), .RST(RST), .EN(EN), .MODE(MODE), .D(D[7:0]), .SIL(SIL), .SIR(SIR),
    .Q(q8), .Qn(qn8), .CO(co8), .ZERO(zero8)
  );

  univ_shift_reg #(.WIDTH(32), .RESET_VALUE(RV32)) u_dut32 (
    .CLK(CLK), .RST(RST), .EN(EN), .MODE(MODE), .D(D), .SIL(SIL), .SIR(SIR),
    .Q(q32), .Qn(qn32), .CO(co32), .ZERO(zero32)
  );

  univ_shift_reg #(.WIDTH(2), .RESET_VALUE(RV2)) u_dut2 (
    .CLK(CLK), .RST(RST), .EN(EN), .MODE(MODE), .D(D[1:0]), .SIL(SIL), .SIR(SIR),
    .Q(q2), .Qn(qn2), .CO(co2), .ZERO(zero2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: returns {co', q'} computed with plain arithmetic on a w-bit value.
  function automatic logic [32:0] model_next(input int w, input logic [31:0] q, input logic co,
                                             input logic rst, input logic en,
                                             input logic [2:0] mode, input logic [31:0] d,
                                             input logic sil, input logic sir,
                                             input logic [31:0] rv);
    logic [31:0] mask, nq, sx;
    logic        nco, msb, lsb;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    msb  = q[w-1];
    lsb  = q[0];
    nq   = q;
    nco  = co;
    if (rst) begin
      nq  = rv;
      nco = 1'b0;
    end else if (en) begin
      case (mode)
        3'd1: nq = d;
        3'd2: begin nq = (q << 1) | 32'(sil);              nco = msb; end
        3'd3: begin nq = (q >> 1) | (32'(sir) << (w - 1)); nco = lsb; end
        3'd4: begin nq = (q << 1) | (q >> (w - 1));        nco = msb; end
        3'd5: begin nq = (q >> 1) | (q << (w - 1));        nco = lsb; end
        3'd6: begin
          sx  = q << (32 - w);
          sx  = $unsigned($signed(sx) >>> 1);
          nq  = sx >> (32 - w);
          nco = lsb;
        end
        3'd7: begin nq = '0; nco = 1'b0; end
        default: nq = q;
      endcase
    end
    return {nco, nq & mask};
  endfunction

  task automatic check_all();
    check_eq("q8", 32'(q8), m8);
    check_eq("qn8", 32'(qn8), ~m8 & 32'hFF);
    check_eq("co8", 32'(co8), 32'(c8));
    check_eq("zero8", 32'(zero8), 32'(m8 == '0));
    check_eq("q32", q32, m32);
    check_eq("qn32", qn32, ~m32);
    check_eq("co32", 32'(co32), 32'(c32));
    check_eq("zero32", 32'(zero32), 32'(m32 == '0));
    check_eq("q2", 32'(q2), m2);
    check_eq("qn2", 32'(qn2), ~m2 & 32'h3);
    check_eq("co2", 32'(co2), 32'(c2));
    check_eq("zero2", 32'(zero2), 32'(m2 == '0));
  endtask

  task automatic cycle(input logic rst, input logic en, input logic [2:0] mode,
                       input logic [31:0] d, input logic sil, input logic sir);
    RST = rst; EN = en; MODE = mode; D = d; SIL = sil; SIR = sir;
    @(posedge CLK);
    {c8, m8}   = model_next(8, m8, c8, rst, en, mode, d & 32'hFF, sil, sir, 32'(RV8));
    {c32, m32} = model_next(32, m32, c32, rst, en, mode, d, sil, sir, RV32);
    {c2, m2}   = model_next(2, m2, c2, rst, en, mode, d & 32'h3, sil, sir, 32'(RV2));
    #1;
    check_all();
  endtask

  logic [7:0] pattern;

  initial begin
    // Reset and hold
    cycle(1'b1, 1'b0, 3'd0, '0, 1'b0, 1'b0);
    check_eq("rst_q", 32'(q8), 32'hA5);
    check_eq("rst_qn", 32'(qn8), 32'h5A);
    check_eq("rst_co", 32'(co8), 32'h0);
    check_eq("rst_zero", 32'(zero8), 32'h0);
    check_eq("rst_q32", q32, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 3'd1, 32'hFF, 1'b1, 1'b1);
    check_eq("hold_q", 32'(q8), 32'hA5);

    // Load and clear
    cycle(1'b0, 1'b1, 3'd1, 32'h00, 1'b0, 1'b0);
    check_eq("load0_zero", 32'(zero8), 32'h1);
    cycle(1'b0, 1'b1, 3'd1, 32'h3C, 1'b0, 1'b0);
    check_eq("load3c", 32'(q8), 32'h3C);
    cycle(1'b0, 1'b1, 3'd7, 32'hFF, 1'b1, 1'b1);
    check_eq("clr_q", 32'(q8), 32'h00);
    check_eq("clr_co", 32'(co8), 32'h0);

    // Shifts from 81
    cycle(1'b0, 1'b1, 3'd1, 32'h81, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 3'd2, '0, 1'b1, 1'b0);
    check_eq("shl_q", 32'(q8), 32'h03);
    check_eq("shl_co", 32'(co8), 32'h1);
    cycle(1'b0, 1'b1, 3'd1, 32'h81, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 3'd3, '0, 1'b1, 1'b0);
    check_eq("shr_q", 32'(q8), 32'h40);
    check_eq("shr_co", 32'(co8), 32'h1);
    cycle(1'b0, 1'b1, 3'd1, 32'h81, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 3'd6, '0, 1'b0, 1'b1);
    check_eq("sar_q", 32'(q8), 32'hC0);
    check_eq("sar_co", 32'(co8), 32'h1);
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 3'd6, '0, 1'b0, 1'b0);
    check_eq("sar_sat", 32'(q8), 32'hFF);

    // Rotates
    pattern = 8'h96;
    cycle(1'b0, 1'b1, 3'd1, 32'h96, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, 3'd4, '0, 1'b1, 1'b1);
      check_eq("rol_co_seq", 32'(co8), 32'(pattern[7-i]));
    end
    check_eq("rol_lossless", 32'(q8), 32'h96);
    cycle(1'b0, 1'b1, 3'd5, '0, 1'b1, 1'b1);
    check_eq("ror_q", 32'(q8), 32'h4B);
    check_eq("ror_co", 32'(co8), 32'h0);

    // Reset aborts a shift sequence
    cycle(1'b0, 1'b1, 3'd1, 32'hF0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 3'd2, '0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 3'd2, '0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 3'd2, '0, 1'b1, 1'b0);
    check_eq("midrst_q", 32'(q8), 32'hA5);
    check_eq("midrst_co", 32'(co8), 32'h0);
    cycle(1'b0, 1'b1, 3'd2, '0, 1'b0, 1'b0);
    check_eq("post_rst_q", 32'(q8), 32'h4A);
    check_eq("post_rst_co", 32'(co8), 32'h1);

    // Width extremes
    cycle(1'b0, 1'b1, 3'd1, 32'h8000_0001, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 3'd5, '0, 1'b0, 1'b0);
    check_eq("ror32_q", q32, 32'hC000_0000);
    check_eq("ror32_co", 32'(co32), 32'h1);
    cycle(1'b0, 1'b1, 3'd1, 32'h2, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 3'd6, '0, 1'b0, 1'b0);
    check_eq("sar2_q", 32'(q2), 32'h3);
    check_eq("sar2_co", 32'(co2), 32'h0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 19) == 0), 1'($urandom), 3'($urandom), $urandom,
            1'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
